// File: rtl/mic_meter_pkg.sv
// Shared constants and helpers for the microphone level meter.
package mic_meter_pkg;

  // Frame-memory layout of the LED matrix.
  localparam logic [15:0] FRAME_MEMORY_START = 16'h4000;
  localparam int          DEF_N_COLS         = 32;
  localparam int          DEF_N_ROWS         = 7;

  // Bar height of one history column (0..N_ROWS).
  typedef logic [2:0] height_t;

  // Byte for pixel at display row `row` (row 0 is the top) of a column whose bar is `height` tall.
  function automatic logic [7:0] pixel_byte(input int row, input int n_rows, input height_t height);
    return (row >= n_rows - int'(height)) ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/mic_meter_pdm_level.sv
// PDM microphone front end: clock divider, sampler, ones counter and bar height.
module mic_meter_pdm_level
  import mic_meter_pkg::*;
#(
  parameter int MIC_DIV = 32,
  parameter int DECIM   = 256,
  parameter int N_ROWS  = DEF_N_ROWS
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    mic_data_i,
  output logic    mic_clk_o,
  output height_t height,
  output logic    valid
);

  localparam int DIV_W  = $clog2(MIC_DIV);
  localparam int CNT_W  = $clog2(DECIM);
  localparam int ONES_W = CNT_W + 1;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(MIC_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(MIC_DIV / 2);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [ONES_W-1:0] ONES_MID = ONES_W'(DECIM / 2);
  localparam logic [ONES_W-1:0] ROWS_W   = ONES_W'(N_ROWS);

  logic [DIV_W-1:0]  div;
  logic [CNT_W-1:0]  sample_cnt;
  logic [ONES_W-1:0] ones;
  logic [ONES_W-1:0] ones_total;
  logic [ONES_W-1:0] level;
  logic [ONES_W-1:0] level_shift;
  height_t           height_calc;
  logic              sample_now;

  // Mic clock is high during the second half of each divider period.
  assign mic_clk_o  = (div >= DIV_HALF);
  assign sample_now = (div == DIV_LAST);

  // Window statistics including the sample being taken this cycle.
  always_comb begin
    ones_total  = ones + ONES_W'(mic_data_i);
    level       = (ones_total >= ONES_MID) ? (ones_total - ONES_MID) : (ONES_MID - ones_total);
    level_shift = level >> 4;
    height_calc = (level_shift > ROWS_W) ? height_t'(N_ROWS) : level_shift[2:0];
  end

  // Divider, sampler and per-window ones counter; emits a one-cycle height pulse per window.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div        <= '0;
      sample_cnt <= '0;
      ones       <= '0;
      height     <= '0;
      valid      <= 1'b0;
    end else begin
      div   <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      valid <= 1'b0;
      if (sample_now) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
        if (sample_cnt == CNT_LAST) begin
          height <= height_calc;
          valid  <= 1'b1;
          ones   <= '0;
        end else begin
          ones <= ones_total;
        end
      end
    end
  end

endmodule

// File: rtl/mic_meter.sv
// Scrolling microphone level meter: keeps a column history of bar heights and
// repaints the whole frame buffer over a shared Wishbone bus after every window.
module mic_meter
  import mic_meter_pkg::*;
#(
  parameter logic [15:0] FRAME_ADDRESS = FRAME_MEMORY_START,
  parameter int          N_COLS        = DEF_N_COLS,
  parameter int          N_ROWS        = DEF_N_ROWS,
  parameter int          MIC_DIV       = 32,
  parameter int          DECIM         = 256,
  parameter int          MAX_WAIT      = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mic_clk_o,
  input  logic        mic_data_i,
  output logic [15:0] adr_o,
  output logic [7:0]  dat_o,
  input  logic [7:0]  dat_i,
  output logic        we_o,
  output logic        sel_o,
  output logic        stb_o,
  output logic [2:0]  cti_o,
  input  logic        ack_i,
  output logic        cyc_o,
  input  logic        cyc_i
);

  typedef enum logic [1:0] {IDLE, REQ, WRITE, NEXT} state_t;

  localparam int COL_W  = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(N_COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(N_ROWS - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

  state_t              state, state_next;
  logic [ROW_W-1:0]    row, row_next;
  logic [COL_W-1:0]    col, col_next;
  logic [COL_W-1:0]    col_inc;
  logic [WAIT_W-1:0]   wait_cnt, wait_next;
  logic                first, first_next;
  logic                cyc, cyc_next;
  logic [7:0]          dat, dat_next;
  logic                render_req, render_req_next;
  logic                stb;
  logic [15:0]         pix_adr;

  height_t             hist [N_COLS];
  height_t             new_height;
  logic                new_valid;

  logic                unused_dat;
  assign unused_dat = ^dat_i;

  mic_meter_pdm_level #(
    .MIC_DIV (MIC_DIV),
    .DECIM   (DECIM),
    .N_ROWS  (N_ROWS)
  ) u_pdm_level (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .mic_data_i (mic_data_i),
    .mic_clk_o  (mic_clk_o),
    .height     (new_height),
    .valid      (new_valid)
  );

  // History scrolls toward column 0 at each window end; newest height enters the last column.
  genvar gi;
  generate
    for (gi = 0; gi < N_COLS; gi++) begin : g_hist
      if (gi < N_COLS - 1) begin : g_shift
        // Interior column takes its right-hand neighbour.
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i)          hist[gi] <= '0;
          else if (new_valid) hist[gi] <= hist[gi+1];
        end
      end else begin : g_in
        // Last column takes the freshly computed height.
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i)          hist[gi] <= '0;
          else if (new_valid) hist[gi] <= new_height;
        end
      end
    end
  endgenerate

  assign col_inc = col + COL_W'(1);
  assign pix_adr = FRAME_ADDRESS + 16'(row) * 16'(N_COLS) + 16'(col);

  // Render FSM next-state logic; the pixel byte is captured before a write begins so
  // it cannot change under a strobe if the history scrolls mid-write.
  always_comb begin
    state_next      = state;
    row_next        = row;
    col_next        = col;
    wait_next       = wait_cnt;
    first_next      = 1'b0;
    cyc_next        = cyc;
    dat_next        = dat;
    render_req_next = render_req;
    case (state)
      IDLE: begin
        if (render_req) begin
          render_req_next = 1'b0;
          row_next        = '0;
          col_next        = '0;
          state_next      = REQ;
        end
      end
      REQ: begin
        dat_next = pixel_byte(int'(row), N_ROWS, hist[col]);
        if (!cyc_i) begin
          cyc_next   = 1'b1;
          first_next = 1'b1;
          wait_next  = '0;
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (first && cyc_i) begin
          // Another master grabbed the bus in the same cycle: back off.
          cyc_next   = 1'b0;
          state_next = REQ;
        end else if (ack_i) begin
          state_next = NEXT;
        end else if (wait_cnt == LAST_WAIT) begin
          cyc_next   = 1'b0;
          state_next = REQ;
        end else begin
          wait_next = wait_cnt + WAIT_W'(1);
        end
      end
      NEXT: begin
        if (col == LAST_COL) begin
          col_next = '0;
          cyc_next = 1'b0;
          if (row == LAST_ROW) begin
            state_next = IDLE;
          end else begin
            row_next   = row + ROW_W'(1);
            state_next = REQ;
          end
        end else begin
          col_next   = col_inc;
          dat_next   = pixel_byte(int'(row), N_ROWS, hist[col_inc]);
          wait_next  = '0;
          state_next = WRITE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (new_valid) render_req_next = 1'b1;
  end

  // Render FSM state and bookkeeping registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      wait_cnt   <= '0;
      first      <= 1'b0;
      cyc        <= 1'b0;
      dat        <= '0;
      render_req <= 1'b0;
    end else begin
      state      <= state_next;
      row        <= row_next;
      col        <= col_next;
      wait_cnt   <= wait_next;
      first      <= first_next;
      cyc        <= cyc_next;
      dat        <= dat_next;
      render_req <= render_req_next;
    end
  end

  // Bus outputs are forced to zero whenever the bus is not owned.
  assign stb   = (state == WRITE) && cyc && !(first && cyc_i);
  assign cyc_o = cyc;
  assign stb_o = stb;
  assign we_o  = stb;
  assign sel_o = stb;
  assign cti_o = 3'b000;
  assign adr_o = cyc ? pix_adr : 16'h0000;
  assign dat_o = cyc ? dat : 8'h00;

endmodule

// File: tb/tb_mic_meter.sv
// Directed bench for the microphone level meter with a simple acking frame memory.
module tb_mic_meter;

  localparam logic [15:0] FRAME = mic_meter_pkg::FRAME_MEMORY_START;
  localparam int NPIX = 224;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mic_clk;
  logic        mic_data;
  logic [15:0] adr;
  logic [7:0]  dat_w;
  logic [7:0]  dat_r = 8'h00;
  logic        we, sel, stb, ack, cyc, cyc_other;
  logic [2:0]  cti;

  logic ack_en    = 1'b1;
  logic mic_const = 1'b0;
  logic alt_mode  = 1'b0;
  logic alt_bit   = 1'b0;

  int checks   = 0;
  int failures = 0;

  int wr_count  = 0;
  int ord_err   = 0;
  int range_err = 0;
  int base      = 0;
  int ord0      = 0;
  int gen       = 1;
  int mon_idx;
  logic [7:0] mem    [NPIX];
  int         memgen [NPIX];

  assign mic_data = alt_mode ? alt_bit : mic_const;
  assign ack      = ack_en & cyc & stb;
  assign mon_idx  = int'(adr) - int'(FRAME);

  always #5 clk = ~clk;

  mic_meter dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mic_clk_o  (mic_clk),
    .mic_data_i (mic_data),
    .adr_o      (adr),
    .dat_o      (dat_w),
    .dat_i      (dat_r),
    .we_o       (we),
    .sel_o      (sel),
    .stb_o      (stb),
    .cti_o      (cti),
    .ack_i      (ack),
    .cyc_o      (cyc),
    .cyc_i      (cyc_other)
  );

  // Alternate the PDM bit once per mic clock period, just after each sample point.
  always @(negedge mic_clk) alt_bit <= ~alt_bit;

  // Frame-memory model: record every acknowledged write and its position in the render order.
  always @(posedge clk) begin
    if (cyc && stb && ack) begin
      if (mon_idx < 0 || mon_idx >= NPIX) begin
        range_err <= range_err + 1;
      end else begin
        mem[mon_idx]    <= dat_w;
        memgen[mon_idx] <= gen;
      end
      if (adr !== FRAME + 16'((wr_count - base) % NPIX)) ord_err <= ord_err + 1;
      wr_count <= wr_count + 1;
      $display("write adr=%h dat=%h we=%b sel=%b cti=%0d", adr, dat_w, we, sel, cti);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected frame: only columns 30 and 31 may carry a bar.
  function automatic int bad_bytes(input int h30, input int h31);
    int bad = 0;
    for (int r = 0; r < 7; r++) begin
      for (int c = 0; c < 32; c++) begin
        int h;
        logic [7:0] e;
        h = (c == 31) ? h31 : ((c == 30) ? h30 : 0);
        e = (r >= 7 - h) ? 8'hFF : 8'h00;
        if (memgen[r*32+c] != gen || mem[r*32+c] !== e) bad++;
      end
    end
    return bad;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    gen++;
    base = wr_count;
    ord0 = ord_err;
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int i = 0;
    while ((wr_count - base) < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'((wr_count - base) >= n), 32'd1);
  endtask

  initial begin
    int n;
    int cnt;
    int w1;
    logic [15:0] saved;
    cyc_other = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_adr", 32'(adr), 32'd0);
    check("rst_dat", 32'(dat_w), 32'd0);
    check("rst_mic_clk", 32'(mic_clk), 32'd0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("mic_clk_low_half", 32'(mic_clk), 32'd0);
    @(negedge clk);
    check("mic_clk_high_half", 32'(mic_clk), 32'd1);

    // Constant ones: full bar in the newest column
    mic_const = 1'b1;
    repeat (8100) @(negedge clk);
    check("t1_no_early_write", 32'(wr_count - base), 32'd0);
    wait_writes(1, 400, "t1_render_start");
    wait_writes(NPIX, 1200, "t1_render_done");
    repeat (30) @(negedge clk);
    check("t1_write_count", 32'(wr_count - base), 32'(NPIX));
    check("t1_bad_bytes", 32'(bad_bytes(0, 7)), 32'd0);
    check("t1_byte_c31_r0", 32'(mem[31]), 32'hFF);
    check("t1_byte_c30_r0", 32'(mem[30]), 32'h00);
    check("t1_byte_c31_r6", 32'(mem[223]), 32'hFF);
    check("t1_byte_c0_r0", 32'(mem[0]), 32'h00);
    check("t1_order", 32'(ord_err - ord0), 32'd0);

    // Alternating bits: zero level, blank frame
    do_reset();
    alt_mode = 1'b1;
    wait_writes(NPIX, 9800, "t2_render_done");
    repeat (30) @(negedge clk);
    alt_mode = 1'b0;
    check("t2_write_count", 32'(wr_count - base), 32'(NPIX));
    check("t2_bad_bytes", 32'(bad_bytes(0, 0)), 32'd0);
    check("t2_order", 32'(ord_err - ord0), 32'd0);

    // Bus held by another master with a render pending
    cyc_other = 1'b1;
    do_reset();
    cnt = 0;
    for (int i = 0; i < 9400; i++) begin
      @(negedge clk);
      if (cyc) cnt++;
    end
    check("t3_cyc_while_busy", 32'(cnt), 32'd0);
    check("t3_no_writes", 32'(wr_count - base), 32'd0);
    cyc_other = 1'b0;
    @(negedge clk);
    check("t3_cyc_after_release", 32'(cyc), 32'd1);
    wait_writes(NPIX, 1500, "t3_render_done");
    repeat (10) @(negedge clk);
    check("t3_bad_bytes", 32'(bad_bytes(0, 7)), 32'd0);

    // Slave never acks: timeout and retry of the same pixel
    do_reset();
    ack_en = 1'b0;
    n = 0;
    while (!stb && n < 9000) begin
      @(negedge clk);
      n++;
    end
    check("t4_stb_seen", 32'(stb), 32'd1);
    saved = adr;
    check("t4_first_adr", 32'(saved), 32'(FRAME));
    n = 0;
    while (stb && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("t4_stb_cycles", 32'(n), 32'd8);
    check("t4_cyc_dropped", 32'(cyc), 32'd0);
    n = 0;
    while (!stb && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t4_retry_adr", 32'(adr), 32'(saved));
    ack_en = 1'b1;
    wait_writes(NPIX, 1500, "t4_render_done");
    repeat (10) @(negedge clk);
    check("t4_order", 32'(ord_err - ord0), 32'd0);

    // Reset in the middle of a render
    do_reset();
    wait_writes(50, 9000, "t5_reach_pixel50");
    n = 0;
    while (!stb && n < 10) begin
      @(negedge clk);
      n++;
    end
    #1 rst = 1'b1;
    #1;
    check("t5_cyc_async", 32'(cyc), 32'd0);
    check("t5_stb_async", 32'(stb), 32'd0);
    check("t5_adr_async", 32'(adr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    gen++;
    base = wr_count;
    ord0 = ord_err;
    repeat (8100) @(negedge clk);
    check("t5_quiet_after_reset", 32'(wr_count - base), 32'd0);

    // Second window ends while the bus is starved mid-render
    wait_writes(50, 700, "t6_reach_pixel50");
    cyc_other = 1'b1;
    repeat (200) @(negedge clk);
    w1 = wr_count;
    repeat (8100) @(negedge clk);
    check("t6_frozen_while_busy", 32'(wr_count), 32'(w1));
    cyc_other = 1'b0;
    wait_writes(2 * NPIX, 3000, "t6_two_renders");
    repeat (30) @(negedge clk);
    check("t6_write_count", 32'(wr_count - base), 32'(2 * NPIX));
    check("t6_bad_bytes", 32'(bad_bytes(7, 7)), 32'd0);
    check("t6_order", 32'(ord_err - ord0), 32'd0);
    check("range_errors", 32'(range_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
